// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage types: FSM state encoding, NOP word and the IF/ID payload.
`default_nettype none

package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register; flush dominates load, otherwise the contents hold.
`default_nettype none

module if_id_reg
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t load_data,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.valid <= 1'b0;
      q.pc    <= 32'h0;
      q.instr <= NOP_WORD;
    end else if (flush) begin
      // pc is left untouched so it stays stable while the slot is invalid
      q.valid <= 1'b0;
      q.instr <= NOP_WORD;
    end else if (load) begin
      q <= load_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC, single-outstanding imem handshake, skid buffer and redirect/flush control.
`default_nettype none

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);
  import fetch_pc_unit_pkg::*;

  fetch_state_e state, state_d;
  logic [31:0]  pc, pc_d, buf_pc, buf_instr, redirect;
  logic         load, flush, capture;
  if_id_t       load_data, if_id_q;

  assign redirect  = br_target & ~32'h3;
  // Gated with rst_n so no request is visible while reset is held
  assign imem_req  = (state == REQ) && rst_n;
  assign imem_addr = pc;

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    load      = 1'b0;
    flush     = 1'b0;
    capture   = 1'b0;
    load_data = '{valid: 1'b1, pc: pc, instr: imem_rdata};
    case (state)
      REQ: begin
        state_d = WAIT;
        if (br_taken) begin
          pc_d    = redirect;
          flush   = 1'b1;
          state_d = DROP;
        end
      end
      WAIT: begin
        if (br_taken) begin
          pc_d    = redirect;
          flush   = 1'b1;
          state_d = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          pc_d = pc + 32'd4;
          if (stall) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            load    = 1'b1;
            state_d = REQ;
          end
        end else if (!stall) begin
          flush = 1'b1;
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_d    = redirect;
          flush   = 1'b1;
          state_d = REQ;
        end else if (!stall) begin
          load      = 1'b1;
          load_data = '{valid: 1'b1, pc: buf_pc, instr: buf_instr};
          state_d   = REQ;
        end
      end
      DROP: begin
        if (br_taken) begin
          pc_d  = redirect;
          flush = 1'b1;
        end
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REQ;
      pc        <= RESET_PC;
      buf_pc    <= 32'h0;
      buf_instr <= NOP_INSTR;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (capture) begin
        buf_pc    <= pc;
        buf_instr <= imem_rdata;
      end
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .flush     (flush),
    .load_data (load_data),
    .q         (if_id_q)
  );

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch stage directly upstream of the branch-condition stage.
- Owns the program counter and drives a single-outstanding instruction-memory request/response handshake.
- Holds the IF/ID pipeline register consumed by decode/execute.
- Takes br_taken and br_target back from execute to redirect the PC and flush wrong-path instructions, including an in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INSTR, 32'h0000_0013, instruction word presented in IF/ID when invalid (addi x0,x0,0)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
br_taken  in  1  redirect request from branch-condition stage (taken branch, JAL, JALR)
br_target  in  32  redirect target address
stall  in  1  hazard stall from decode; hold IF/ID and PC
imem_req  out  1  instruction fetch request, one-cycle pulse
imem_addr  out  32  fetch address, valid when imem_req=1
imem_rvalid  in  1  fetch response valid, at least 1 cycle after request
imem_rdata  in  32  fetched instruction word
if_id_valid  out  1  IF/ID register holds a valid instruction
if_id_pc  out  32  PC of the IF/ID instruction
if_id_instr  out  32  IF/ID instruction word

Behaviour:
- Reset is async on rst_n low:
  - pc=RESET_PC, state=REQ, skid buffer empty.
  - imem_req=0, imem_addr=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR.
- Redirect address is {br_target[31:2],2'b00}; the low 2 bits are always forced to zero.
- State machine: REQ, WAIT, HOLD, DROP.
- REQ:
  - imem_req=1, imem_addr=pc; next state WAIT.
  - If br_taken is high this cycle: pc<=target, the request still issues on the old pc, and the next state is DROP instead of WAIT.
- WAIT: imem_req=0. Priority is br_taken > stall > normal.
  - br_taken & imem_rvalid: discard the response, pc<=target, flush IF/ID (if_id_valid<=0, if_id_instr<=NOP_INSTR), go to REQ.
  - br_taken & ~imem_rvalid: pc<=target, flush IF/ID, go to DROP.
  - ~br_taken & imem_rvalid & stall: latch {pc, imem_rdata} into the skid buffer, pc<=pc+4, go to HOLD. IF/ID is unchanged.
  - ~br_taken & imem_rvalid & ~stall: IF/ID<= {1, pc, imem_rdata}, pc<=pc+4, go to REQ.
  - No rvalid & ~br_taken: stay in WAIT. If ~stall, clear if_id_valid (bubble).
- HOLD:
  - br_taken: discard the buffer, pc<=target, flush IF/ID, go to REQ.
  - ~stall: IF/ID<=buffer (valid=1), go to REQ.
  - Otherwise: stay in HOLD with IF/ID held.
- DROP:
  - Waits for the wrong-path response, which is discarded.
  - On imem_rvalid, go to REQ.
  - br_taken in DROP: update pc to the new target and stay in DROP until rvalid.
- Stall with no new data (REQ/WAIT/DROP): IF/ID holds. stall never blocks a flush.
- If_id contents:
  - Every flush sets if_id_instr=NOP_INSTR and if_id_valid=0.
  - if_id_pc is don't-care when invalid but must be held stable.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- Steady-state throughput: one instruction per 2 cycles with 1-cycle memory latency. Higher throughput is out of scope.
- The imem_rvalid response is ignored in REQ and HOLD. Memory contract: no response without an outstanding request.

Decomposition:
- Shared core package:
  - fetch_state_e enum {REQ, WAIT, HOLD, DROP}.
  - NOP_INSTR constant.
  - if_id_t packed struct {valid, pc[31:0], instr[31:0]}; also used by decode.
- One natural sub-module, if_id_reg:
  - Async active-low reset.
  - load / flush / hold control; flush dominates load.
- PC register and FSM stay in fetch_pc_unit.

Test Plan:
1. Reset release, RESET_PC=0, memory returns 0x00500093 at addr 0 one cycle after each request -> imem_req pulses at addr 0, 4, 8; if_id {valid=1, pc=0, instr=0x00500093} appears 2 cycles after reset release.
2. Stall asserted during WAIT when rvalid arrives with pc=0x10 -> IF/ID unchanged, FSM enters HOLD. Stall released 3 cycles later -> IF/ID={1, 0x10, data}, next request at 0x14.
3. br_taken=1, br_target=0x200 in WAIT with no rvalid -> IF/ID flushed to NOP/valid=0, state DROP. The late response is discarded, the next request is at 0x200, and the first valid IF/ID pc is 0x200.
4. br_taken with br_target=0x103 simultaneous with stall=1 and rvalid=1 -> the flush wins, pc=0x100, and no buffer capture occurs.
5. rst_n asserted in the middle of WAIT, after an outstanding request to 0x40 -> all outputs return to reset values immediately (asynchronously). After release, the first request is at RESET_PC.
6. pc=0xFFFF_FFFC, fetch completes -> next imem_addr=0x0000_0000.
